booth_mul_arbiter: RTL and testbench

//  Shares one sequential 32x32 signed Booth multiplier among NUM_REQ requesters.

---
 rtl/booth_mul_arbiter.sv | 130 +++++++++++++
 tb/tb_booth_mul_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mul_arbiter.sv
// Round-robin front end that shares one sequential signed multiplier among NUM_REQ
// requesters, with a watchdog that aborts an operation the multiplier never finishes.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no operation; grant the next requester, latch its operands
// S_ISSUE | one-cycle mul_start pulse, watchdog cleared
// S_WAIT  | wait for mul_done or the watchdog limit
// S_RESP  | one-cycle rsp_valid pulse to the owner
module booth_mul_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 40
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*WIDTH-1:0] req_a,
   input  logic [NUM_REQ*WIDTH-1:0] req_b,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic [NUM_REQ-1:0]       rsp_valid,
   output logic [2*WIDTH-1:0]       rsp_product,
   output logic                     rsp_err,
   output logic                     mul_start,
   output logic [WIDTH-1:0]         mul_a,
   output logic [WIDTH-1:0]         mul_b,
   input  logic [2*WIDTH-1:0]       mul_product,
   input  logic                     mul_done,
   output logic                     busy
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t          state, state_nxt;
   logic [PW-1:0]   rr_ptr;
   logic [PW-1:0]   owner;
   logic [PW-1:0]   grant;
   logic [PW-1:0]   scan_idx;
   logic            grant_vld;
   logic [7:0]      wait_cnt;
   logic            wait_tc;

   // Scan from the highest offset down so the requester nearest rr_ptr wins.
   always_comb begin
      grant     = '0;
      grant_vld = 1'b0;
      scan_idx  = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         scan_idx = PW'((int'(rr_ptr) + i) % NUM_REQ);
         if (req_valid[scan_idx]) begin
            grant     = scan_idx;
            grant_vld = 1'b1;
         end
      end
   end

   assign wait_tc = (wait_cnt == 8'(TIMEOUT - 1));

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      req_ready = '0;
      rsp_valid = '0;
      mul_start = 1'b0;
      busy      = (state != S_IDLE);
      case (state)
         S_IDLE: begin
            if (grant_vld) begin
               req_ready[grant] = 1'b1;
               state_nxt        = S_ISSUE;
            end
         end
         S_ISSUE: begin
            mul_start = 1'b1;
            state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (mul_done || wait_tc) state_nxt = S_RESP;
         end
         S_RESP: begin
            rsp_valid[owner] = 1'b1;
            state_nxt        = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rr_ptr      <= '0;
         owner       <= '0;
         wait_cnt    <= '0;
         mul_a       <= '0;
         mul_b       <= '0;
         rsp_product <= '0;
         rsp_err     <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (grant_vld) begin
                  mul_a  <= req_a[int'(grant)*WIDTH +: WIDTH];
                  mul_b  <= req_b[int'(grant)*WIDTH +: WIDTH];
                  owner  <= grant;
                  rr_ptr <= PW'((int'(grant) + 1) % NUM_REQ);
               end
            end
            S_ISSUE: wait_cnt <= '0;
            S_WAIT: begin
               wait_cnt <= wait_cnt + 8'd1;
               // A result arriving on the watchdog's last cycle still counts.
               if (mul_done) begin
                  rsp_product <= mul_product;
                  rsp_err     <= 1'b0;
               end else if (wait_tc) begin
                  rsp_product <= '0;
                  rsp_err     <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Directed bench for booth_mul_arbiter: a small multiplier model with programmable
// latency, hand-computed products, arbitration order, watchdog and reset cases.
module tb_booth_mul_arbiter;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic [3:0]    req_valid = '0;
   logic [127:0]  req_a = '0;
   logic [127:0]  req_b = '0;
   logic [3:0]    req_ready;
   logic [3:0]    rsp_valid;
   logic [63:0]   rsp_product;
   logic          rsp_err;
   logic          mul_start;
   logic [31:0]   mul_a;
   logic [31:0]   mul_b;
   logic [63:0]   mul_product;
   logic          mul_done;
   logic          busy;

   int checks = 0;
   int errors = 0;

   logic          model_en = 1'b1;
   int            model_delay = 3;
   int            mcnt;
   logic          model_done;
   logic [63:0]   model_prod;
   logic          man_done = 1'b0;

   booth_mul_arbiter #(.NUM_REQ(4), .WIDTH(32), .TIMEOUT(40)) dut (
      .CLK(CLK), .RST(RST),
      .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_product(rsp_product), .rsp_err(rsp_err),
      .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
      .mul_product(mul_product), .mul_done(mul_done), .busy(busy)
   );

   always #5 CLK = ~CLK;

   // Multiplier model: mul_done lands model_delay cycles after the start cycle.
   always @(posedge CLK or posedge RST) begin
      if (RST) begin
         mcnt       <= 0;
         model_done <= 1'b0;
         model_prod <= '0;
      end else begin
         model_done <= 1'b0;
         if (mul_start && model_en) begin
            mcnt       <= model_delay - 1;
            model_done <= (model_delay == 1);
            model_prod <= {{32{mul_a[31]}}, mul_a} * {{32{mul_b[31]}}, mul_b};
         end else if (mcnt > 0) begin
            mcnt       <= mcnt - 1;
            model_done <= (mcnt == 1);
         end
      end
   end

   assign mul_done    = model_done | man_done;
   assign mul_product = model_prod;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic wait_rsp(output int cyc, output logic [3:0] v, output logic [63:0] p,
                           output logic e, output logic seen);
      cyc = 0; v = '0; p = '0; e = 1'b0; seen = 1'b0;
      while (cyc < 300 && !seen) begin
         @(negedge CLK);
         cyc++;
         if (rsp_valid != '0) begin
            v = rsp_valid; p = rsp_product; e = rsp_err; seen = 1'b1;
         end
      end
   endtask

   task automatic reset_dut();
      RST = 1'b1;
      #1;
      chk("rst_req_ready", 64'(req_ready), 0);
      chk("rst_rsp_valid", 64'(rsp_valid), 0);
      chk("rst_rsp_product", rsp_product, 0);
      chk("rst_rsp_err", 64'(rsp_err), 0);
      chk("rst_mul_start", 64'(mul_start), 0);
      chk("rst_mul_a", 64'(mul_a), 0);
      chk("rst_mul_b", 64'(mul_b), 0);
      chk("rst_busy", 64'(busy), 0);
      @(negedge CLK);
      @(negedge CLK);
      RST = 1'b0;
   endtask

   // Called just after a negedge in IDLE; returns just after a negedge back in IDLE.
   task automatic op(input int r, input logic [31:0] a, input logic [31:0] b,
                     input logic [63:0] exp_p, input logic exp_e, input int exp_cyc,
                     input logic issue_pulse);
      int cyc; logic [3:0] v; logic [63:0] p; logic e; logic seen;
      req_a[r*32 +: 32] = a;
      req_b[r*32 +: 32] = b;
      req_valid[r] = 1'b1;
      #1;
      chk("op_ready", 64'(req_ready), 64'(1 << r));
      @(negedge CLK);
      req_valid[r] = 1'b0;
      chk("op_start", 64'(mul_start), 1);
      chk("op_mul_a", 64'(mul_a), 64'(a));
      if (issue_pulse) begin
         man_done = 1'b1;
         @(posedge CLK);
         #1 man_done = 1'b0;
      end
      wait_rsp(cyc, v, p, e, seen);
      chk("op_rsp_seen", 64'(seen), 1);
      chk("op_owner", 64'(v), 64'(1 << r));
      chk("op_product", p, exp_p);
      chk("op_err", 64'(e), 64'(exp_e));
      chk("op_latency", 64'(cyc), 64'(exp_cyc));
      @(negedge CLK);
      chk("op_hold_product", rsp_product, exp_p);
   endtask

   logic [63:0] exp2 [4];
   logic [31:0] a2 [4];
   logic [31:0] b2 [4];

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation time limit");
      $fatal(1);
   end

   initial begin
      int cyc; logic [3:0] v; logic [63:0] p; logic e; logic seen; int cnt;

      @(negedge CLK);
      reset_dut();

      // single request, 33-cycle multiplier
      model_en = 1'b1; model_delay = 33;
      op(0, 32'd3, 32'hFFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0, 34, 1'b0);

      // round-robin from reset with all four requesting continuously
      reset_dut();
      model_delay = 3;
      a2[0] = 32'd7;          b2[0] = 32'd6;          exp2[0] = 64'd42;
      a2[1] = 32'hFFFF_FFFF;  b2[1] = 32'hFFFF_FFFF;  exp2[1] = 64'd1;
      a2[2] = 32'h7FFF_FFFF;  b2[2] = 32'd2;          exp2[2] = 64'h0000_0000_FFFF_FFFE;
      a2[3] = 32'h8000_0000;  b2[3] = 32'd1;          exp2[3] = 64'hFFFF_FFFF_8000_0000;
      for (int i = 0; i < 4; i++) begin
         req_a[i*32 +: 32] = a2[i];
         req_b[i*32 +: 32] = b2[i];
      end
      req_valid = 4'hF;
      #1;
      for (int k = 0; k < 5; k++) begin
         chk("rr_ready", 64'(req_ready), 64'(1 << (k % 4)));
         @(negedge CLK);
         if (k == 4) req_valid = '0;
         wait_rsp(cyc, v, p, e, seen);
         chk("rr_rsp_seen", 64'(seen), 1);
         chk("rr_owner", 64'(v), 64'(1 << (k % 4)));
         chk("rr_product", p, exp2[k % 4]);
         @(negedge CLK);
      end

      // watchdog: multiplier never answers, then a normal operation
      model_en = 1'b0;
      op(1, 32'd5, 32'd5, 64'd0, 1'b1, 41, 1'b0);
      model_en = 1'b1; model_delay = 5;
      op(1, 32'hFFFF_FFFD, 32'd4, 64'hFFFF_FFFF_FFFF_FFF4, 1'b0, 6, 1'b0);

      // done on the last watchdog cycle wins; one cycle later is a timeout
      model_delay = 40;
      op(3, 32'd9, 32'd9, 64'd81, 1'b0, 41, 1'b0);
      model_delay = 41;
      op(3, 32'd9, 32'd9, 64'd0, 1'b1, 41, 1'b0);

      // stray mul_done during ISSUE is ignored
      model_delay = 10;
      op(2, 32'd100, 32'hFFFF_FFF6, 64'hFFFF_FFFF_FFFF_FC18, 1'b0, 11, 1'b1);

      // reset in the middle of WAIT
      model_en = 1'b0;
      req_a[64 +: 32] = 32'd12; req_b[64 +: 32] = 32'd12;
      req_valid = 4'b0001;
      @(negedge CLK);
      req_valid = '0;
      repeat (5) @(negedge CLK);
      chk("pre_rst_busy", 64'(busy), 1);
      reset_dut();
      cnt = 0;
      repeat (45) begin
         @(negedge CLK);
         if (rsp_valid != '0 || busy) cnt++;
      end
      chk("post_rst_quiet", 64'(cnt), 0);
      model_en = 1'b1; model_delay = 2;
      op(2, 32'd12, 32'd12, 64'd144, 1'b0, 3, 1'b0);

      // requester 1 withdraws while requester 0 is in WAIT
      model_delay = 4;
      req_a[0 +: 32] = 32'd11;  req_b[0 +: 32] = 32'hFFFF_FFFE;
      req_a[32 +: 32] = 32'd5;  req_b[32 +: 32] = 32'd5;
      req_valid = 4'b0011;
      #1;
      chk("drop_ready", 64'(req_ready), 64'b0001);
      @(negedge CLK);
      req_valid[0] = 1'b0;
      @(negedge CLK);
      req_valid[1] = 1'b0;
      wait_rsp(cyc, v, p, e, seen);
      chk("drop_rsp_seen", 64'(seen), 1);
      chk("drop_owner", 64'(v), 64'b0001);
      chk("drop_product", p, 64'hFFFF_FFFF_FFFF_FFEA);
      cnt = 0;
      repeat (12) begin
         @(negedge CLK);
         if (rsp_valid != '0 || req_ready != '0 || busy) cnt++;
      end
      chk("drop_no_req1_op", 64'(cnt), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
